store_buffer_16bit: RTL

Posted-store buffer between the CPU memory-access stage and `Data_Memory_16bit`. Stores are accepted into a small FIFO and return immediately. They drain to the data memory one per cycle whenever the memory port is not needed by a load. Loads have priority on the port, return data with one-cycle latency, and take their data from the newest matching buffered store when one exists.

---
 rtl/store_buffer_16bit_pkg.sv | 18 +
 rtl/store_buffer_16bit_if.sv | 34 +++
 rtl/store_buffer_16bit_fwd_match.sv | 39 +++
 rtl/store_buffer_16bit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/store_buffer_16bit_pkg.sv
// Shared types and sizes for the 16-bit CPU store buffer.
// Holds address/data widths, buffer depth, pointer width and the entry type.
package cpu16_pkg;

   localparam int CPU_AW   = 16;
   localparam int CPU_DW   = 16;
   localparam int SB_DEPTH = 4;
   localparam int SB_PW    = $clog2(SB_DEPTH);

   typedef logic [CPU_AW-1:0] addr_t;
   typedef logic [CPU_DW-1:0] data_t;

   typedef struct packed {
      addr_t addr;
      data_t data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_16bit_if.sv
// CPU-side store/load handshake bundle of the store buffer.
// master = memory-access stage, slave = store buffer.
interface store_buffer_16bit_if
   import cpu16_pkg::*;
#(
   parameter int AW = CPU_AW,
   parameter int DW = CPU_DW
);

   logic          st_valid;
   logic [AW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_ready;
   logic          ld_valid;
   logic [AW-1:0] ld_addr;
   logic          ld_ready;
   logic          ld_rvalid;
   logic [DW-1:0] ld_rdata;

   modport master (
      output st_valid, st_addr, st_data,
      output ld_valid, ld_addr,
      input  st_ready, ld_ready,
      input  ld_rvalid, ld_rdata
   );

   modport slave (
      input  st_valid, st_addr, st_data,
      input  ld_valid, ld_addr,
      output st_ready, ld_ready,
      output ld_rvalid, ld_rdata
   );

endinterface

// File: rtl/store_buffer_16bit_fwd_match.sv
// Age-ordered match of a load address against buffered stores.
// Ports: addr/vld entries, head/tail pointers, ld_addr in; hit/idx out.
module sb_fwd_match
   import cpu16_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = CPU_AW
) (
   input  logic [AW-1:0]            addr [DEPTH],
   input  logic [DEPTH-1:0]         vld,
   input  logic [$clog2(DEPTH)-1:0] head,
   input  logic [$clog2(DEPTH)-1:0] tail,
   input  logic [AW-1:0]            ld_addr,
   output logic                     hit,
   output logic [$clog2(DEPTH)-1:0] idx
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] ptr;
   logic          done;

   // Walk from newest (tail-1) back to oldest (head); first match wins.
   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      done = 1'b0;
      ptr  = tail - 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         if (!done && !hit && vld[ptr] && addr[ptr] == ld_addr) begin
            hit = 1'b1;
            idx = ptr;
         end
         done = done | (ptr == head);
         ptr  = ptr - 1'b1;
      end
   end

endmodule

// File: rtl/store_buffer_16bit.sv
// Posted-store buffer between the memory stage and data memory.
// Ports: clk, rst, cpu (slave handshake), mem_* memory port, empty.
module store_buffer_16bit
   import cpu16_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = CPU_AW,
   parameter int DW    = CPU_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   store_buffer_16bit_if.slave  cpu,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_wdata,
   output logic                 mem_read,
   output logic                 mem_write,
   input  logic [DW-1:0]        mem_rdata,
   output logic                 empty
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW:0]      count;
   logic [DEPTH-1:0] vld;

   logic             full;
   logic             ld_acc;
   logic             st_acc;
   logic             pop;
   logic             hit;
   logic [PW-1:0]    hit_idx;
   logic [DW-1:0]    fwd_data;
   logic             ld_rvalid_q;
   logic [DW-1:0]    ld_rdata_q;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   assign cpu.st_ready  = ~full;
   assign cpu.ld_ready  = ~full;
   assign cpu.ld_rvalid = ld_rvalid_q;
   assign cpu.ld_rdata  = ld_rdata_q;

   // Reset wins over every handshake, including the drain.
   assign ld_acc = ~rst & cpu.ld_valid & ~full;
   assign st_acc = ~rst & cpu.st_valid & ~full;
   assign pop    = ~rst & ~ld_acc & ~empty;

   // Entry i is live when its distance from head is below count.
   always_comb begin
      vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld[i] = {1'b0, PW'(PW'(i) - head)} < count;
      end
   end

   sb_fwd_match #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fwd (
      .addr    (addr_q),
      .vld     (vld),
      .head    (head),
      .tail    (tail),
      .ld_addr (cpu.ld_addr),
      .hit     (hit),
      .idx     (hit_idx)
   );

   assign fwd_data = hit ? data_q[hit_idx] : mem_rdata;

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (1'b1)
         ld_acc: begin
            mem_read = 1'b1;
            mem_addr = cpu.ld_addr;
         end
         pop: begin
            mem_write = 1'b1;
            mem_addr  = addr_q[head];
            mem_wdata = data_q[head];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (st_acc) begin
         addr_q[tail] <= cpu.st_addr;
         data_q[tail] <= cpu.st_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (st_acc) tail <= tail + 1'b1;
         if (pop)    head <= head + 1'b1;
         unique case ({st_acc, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // A load captures its data before a same-cycle store lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         ld_rvalid_q <= 1'b0;
         ld_rdata_q  <= '0;
      end else begin
         ld_rvalid_q <= ld_acc;
         if (ld_acc) ld_rdata_q <= fwd_data;
      end
   end

endmodule
